// File: rtl/paddle_ctl_n.sv
// paddle_ctl_n -- multi-channel paddle controller.
//
// Each channel drives one analog paddle position and one fire button. The
// value comes from one of three sources: a physical paddle, an analog stick,
// or a PS/2 mouse shared by all channels. Each channel remembers its current
// source and which stick/mouse axis it follows.
//
// Ports
//   clk, reset_n        system clock; asynchronous active-low reset
//   inv[NCH]            per-channel inversion of the analog output
//   stick_btn[NCH]      select the analog stick as source
//   joy_a[16*NCH]       per-channel stick, [15:8] Y, [7:0] X, signed
//   paddle_btn[NCH]     select the physical paddle as source
//   paddle[8*NCH]       per-channel paddle position, signed
//   ps2_mouse[25]       [24] toggle strobe, [23:16] dY, [15:8] dX,
//                       [5]/[4] Y/X sign, [1:0] buttons
//   mouse_ch[2]         channel that owns the mouse
//   tick                one-cycle strobe that advances the slew limiter
//   b_out[NCH]          registered fire button
//   a_out[AW*NCH]       analog position (8-bit value, top bits replicated)
//   src[2*NCH]          active source: 0 paddle, 1 stick, 2 mouse
//
// Handshake: there is no valid/ready pairing. A mouse report is any cycle in
// which ps2_mouse[24] differs from the copy registered on the previous edge;
// it is consumed on that same edge by the owning channel only.
module paddle_ctl_n #(
  parameter int NCH       = 4,
  parameter int AW        = 8,
  parameter int MDCLAMP   = 10,
  parameter int STICK_THR = 100,
  parameter int SLEW      = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCH-1:0]      inv,
  input  logic [NCH-1:0]      stick_btn,
  input  logic [16*NCH-1:0]   joy_a,
  input  logic [NCH-1:0]      paddle_btn,
  input  logic [8*NCH-1:0]    paddle,
  input  logic [24:0]         ps2_mouse,
  input  logic [1:0]          mouse_ch,
  input  logic                tick,
  output logic [NCH-1:0]      b_out,
  output logic [AW*NCH-1:0]   a_out,
  output logic [2*NCH-1:0]    src
);

  typedef enum logic [1:0] {
    SRC_PADDLE = 2'd0,
    SRC_STICK  = 2'd1,
    SRC_MOUSE  = 2'd2
  } src_t;

  localparam logic signed [8:0] CLAMP_P   = 9'(MDCLAMP);
  localparam logic signed [8:0] CLAMP_N   = -CLAMP_P;
  localparam logic signed [8:0] THR       = 9'(STICK_THR);
  localparam logic [7:0]        SLEW_STEP = 8'(SLEW);

  function automatic logic signed [8:0] clamp_delta(input logic signed [8:0] v);
    if (v > CLAMP_P) return CLAMP_P;
    if (v < CLAMP_N) return CLAMP_N;
    return v;
  endfunction

  // 10-bit sum so the saturation test sees the true result.
  function automatic logic signed [8:0] sat_add(input logic signed [8:0] a,
                                               input logic signed [8:0] b);
    logic signed [9:0] s;
    s = {a[8], a} + {b[8], b};
    if (s > 10'sd127)  return 9'sd127;
    if (s < -10'sd128) return -9'sd128;
    return s[8:0];
  endfunction

  // Shared mouse report detection and delta conditioning.
  logic              strobe_q;
  logic              strobe_d;
  logic              mouse_rpt;
  logic signed [8:0] dx_c;
  logic signed [8:0] dy_c;
  logic              unused_mouse_bits;

  assign strobe_d          = ps2_mouse[24];
  assign mouse_rpt         = ps2_mouse[24] ^ strobe_q;
  assign dx_c              = clamp_delta({ps2_mouse[4], ps2_mouse[15:8]});
  assign dy_c              = clamp_delta({ps2_mouse[5], ps2_mouse[23:16]});
  assign unused_mouse_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_q <= 1'b0;
    else          strobe_q <= strobe_d;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    src_t              src_q, src_d;
    logic              xy_q, xy_d;
    logic signed [8:0] mx_q, mx_d, my_q, my_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        out8_q, out8_d;
    logic              b_q, b_d;
    logic              owner, evt;
    logic [7:0]        jx, jy, adj, diff;

    // mouse_ch values >= NCH never match any generated channel.
    assign owner = (mouse_ch == 2'(g));
    assign evt   = mouse_rpt & owner;
    assign jx    = joy_a[16*g +: 8];
    assign jy    = joy_a[16*g+8 +: 8];

    always_comb begin
      src_d = src_q;
      if (paddle_btn[g])     src_d = SRC_PADDLE;
      else if (stick_btn[g]) src_d = SRC_STICK;
      else if (evt)          src_d = SRC_MOUSE;

      // Accumulators follow every owned report, whatever the source, and are
      // kept while ownership is elsewhere.
      mx_d = mx_q;
      my_d = my_q;
      if (evt) begin
        mx_d = sat_add(mx_q, dx_c);
        my_d = sat_add(my_q, dy_c);
      end

      xy_d = xy_q;
      if (src_d == SRC_MOUSE && evt) begin
        if (ps2_mouse[0])      xy_d = 1'b0;
        else if (ps2_mouse[1]) xy_d = 1'b1;
      end else if (src_d == SRC_STICK) begin
        if (!jx[7] && $signed({1'b0, jx}) > THR)      xy_d = 1'b0;
        else if (!jy[7] && $signed({1'b0, jy}) > THR) xy_d = 1'b1;
      end

      // Target uses the next-state source so a source change takes effect
      // on the same edge.
      case (src_d)
        SRC_PADDLE: target_d = {~paddle[8*g+7], paddle[8*g +: 7]};
        SRC_STICK:  target_d = xy_d ? jy : jx;
        SRC_MOUSE:  target_d = xy_d ? my_d[7:0] : mx_d[7:0];
        default:    target_d = target_q;
      endcase

      case (src_d)
        SRC_PADDLE: b_d = paddle_btn[g];
        SRC_STICK:  b_d = stick_btn[g];
        SRC_MOUSE:  b_d = owner & (|ps2_mouse[1:0]);
        default:    b_d = 1'b0;
      endcase

      adj    = inv[g] ? ~target_q : target_q;
      diff   = 8'd0;
      out8_d = out8_q;
      if (SLEW == 0) begin
        out8_d = adj;
      end else if (tick) begin
        // Step is the smaller of SLEW and the distance, so it cannot overshoot.
        if (adj > out8_q) begin
          diff   = adj - out8_q;
          out8_d = out8_q + ((diff > SLEW_STEP) ? SLEW_STEP : diff);
        end else begin
          diff   = out8_q - adj;
          out8_d = out8_q - ((diff > SLEW_STEP) ? SLEW_STEP : diff);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        src_q    <= SRC_PADDLE;
        xy_q     <= 1'b0;
        mx_q     <= '0;
        my_q     <= '0;
        target_q <= 8'h80;
        out8_q   <= 8'h80;
        b_q      <= 1'b0;
      end else begin
        src_q    <= src_d;
        xy_q     <= xy_d;
        mx_q     <= mx_d;
        my_q     <= my_d;
        target_q <= target_d;
        out8_q   <= out8_d;
        b_q      <= b_d;
      end
    end

    assign src[2*g +: 2] = src_q;
    assign b_out[g]      = b_q;

    if (AW == 8) begin : g_aw8
      assign a_out[AW*g +: AW] = out8_q;
    end else begin : g_awx
      assign a_out[AW*g +: AW] = {out8_q, out8_q[7:16-AW]};
    end
  end

endmodule

// File: tb/tb_paddle_ctl_n.sv
module tb_paddle_ctl_n;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk;
  logic        reset_n;
  logic [3:0]  inv, stick_btn, paddle_btn;
  logic [63:0] joy_a;
  logic [31:0] paddle;
  logic [24:0] ps2_mouse;
  logic [1:0]  mouse_ch;
  logic        tick;

  logic [3:0]  b0, b1;
  logic [31:0] a0;
  logic [39:0] a1;
  logic [7:0]  s0, s1;

  int n_tests = 0;
  int n_fail  = 0;

  paddle_ctl_n #(.NCH(4), .AW(8), .MDCLAMP(10), .STICK_THR(100), .SLEW(0)) u0 (
    .clk(clk), .reset_n(reset_n), .inv(inv), .stick_btn(stick_btn), .joy_a(joy_a),
    .paddle_btn(paddle_btn), .paddle(paddle), .ps2_mouse(ps2_mouse),
    .mouse_ch(mouse_ch), .tick(tick), .b_out(b0), .a_out(a0), .src(s0));

  paddle_ctl_n #(.NCH(4), .AW(10), .MDCLAMP(10), .STICK_THR(100), .SLEW(4)) u1 (
    .clk(clk), .reset_n(reset_n), .inv(inv), .stick_btn(stick_btn), .joy_a(joy_a),
    .paddle_btn(paddle_btn), .paddle(paddle), .ps2_mouse(ps2_mouse),
    .mouse_ch(mouse_ch), .tick(tick), .b_out(b1), .a_out(a1), .src(s1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  int m_src[4], m_xy[4], m_mx[4], m_my[4], m_tgt[4], m_out0[4], m_out1[4], m_b[4];
  bit m_strobe;

  function automatic int sb(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int lim(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int aw10(input int x);
    return x * 4 + x / 64;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_src[ch] = 0; m_xy[ch] = 0; m_mx[ch] = 0; m_my[ch] = 0;
      m_tgt[ch] = 128; m_out0[ch] = 128; m_out1[ch] = 128; m_b[ch] = 0;
    end
    m_strobe = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit rpt, own;
    int adj, dx, dy, jx, jy;
    rpt = (ps2_mouse[24] != m_strobe);
    for (int ch = 0; ch < 4; ch++) begin
      own = rpt && (int'(mouse_ch) == ch);
      adj = inv[ch] ? 255 - m_tgt[ch] : m_tgt[ch];
      m_out0[ch] = adj;
      if (tick) m_out1[ch] += lim(adj - m_out1[ch], -4, 4);
      if (paddle_btn[ch])     m_src[ch] = 0;
      else if (stick_btn[ch]) m_src[ch] = 1;
      else if (own)           m_src[ch] = 2;
      if (own) begin
        dx = ps2_mouse[4] ? int'(ps2_mouse[15:8]) - 256 : int'(ps2_mouse[15:8]);
        dy = ps2_mouse[5] ? int'(ps2_mouse[23:16]) - 256 : int'(ps2_mouse[23:16]);
        m_mx[ch] = lim(m_mx[ch] + lim(dx, -10, 10), -128, 127);
        m_my[ch] = lim(m_my[ch] + lim(dy, -10, 10), -128, 127);
      end
      jx = sb(joy_a[16*ch +: 8]);
      jy = sb(joy_a[16*ch+8 +: 8]);
      if (m_src[ch] == 2 && own) begin
        if (ps2_mouse[0])      m_xy[ch] = 0;
        else if (ps2_mouse[1]) m_xy[ch] = 1;
      end else if (m_src[ch] == 1) begin
        if (jx > 100)      m_xy[ch] = 0;
        else if (jy > 100) m_xy[ch] = 1;
      end
      case (m_src[ch])
        0:       m_tgt[ch] = (int'(paddle[8*ch +: 8]) + 128) % 256;
        1:       m_tgt[ch] = (m_xy[ch] ? jy : jx) & 255;
        default: m_tgt[ch] = (m_xy[ch] ? m_my[ch] : m_mx[ch]) & 255;
      endcase
      case (m_src[ch])
        0:       m_b[ch] = int'(paddle_btn[ch]);
        1:       m_b[ch] = int'(stick_btn[ch]);
        default: m_b[ch] = (int'(mouse_ch) == ch) ? int'(|ps2_mouse[1:0]) : 0;
      endcase
    end
    m_strobe = ps2_mouse[24];
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("a0_ch%0d", ch),  32'(a0[8*ch +: 8]),  m_out0[ch]);
      chk($sformatf("a1_ch%0d", ch),  32'(a1[10*ch +: 10]), aw10(m_out1[ch]));
      chk($sformatf("src0_ch%0d", ch), 32'(s0[2*ch +: 2]), m_src[ch]);
      chk($sformatf("src1_ch%0d", ch), 32'(s1[2*ch +: 2]), m_src[ch]);
      chk($sformatf("b0_ch%0d", ch),  32'(b0[ch]), m_b[ch]);
      chk($sformatf("b1_ch%0d", ch),  32'(b1[ch]), m_b[ch]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic mouse_report(input int dx, input int dy, input logic [1:0] btn);
    ps2_mouse[24]    = ~ps2_mouse[24];
    ps2_mouse[15:8]  = dx[7:0];
    ps2_mouse[4]     = (dx < 0);
    ps2_mouse[23:16] = dy[7:0];
    ps2_mouse[5]     = (dy < 0);
    ps2_mouse[1:0]   = btn;
    cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b1; inv = '0; stick_btn = '0; paddle_btn = '0; joy_a = '0;
    paddle = '0; ps2_mouse = '0; mouse_ch = 2'd0; tick = 1'b0;
    model_reset();
    #1;
    do_reset();
    chk("rst_a0", 32'(a0[7:0]), 32'h80);
    chk("rst_a1", 32'(a1[9:0]), 32'h202);

    // Paddle at zero reads mid-scale; inversion gives 7F.
    repeat (2) cycle();
    chk("pad0_inv0", 32'(a0[7:0]), 32'h80);
    inv[0] = 1'b1;
    repeat (2) cycle();
    chk("pad0_inv1", 32'(a0[7:0]), 32'h7F);
    inv[0] = 1'b0;

    // Paddle button beats stick button.
    paddle_btn[0] = 1'b1; stick_btn[0] = 1'b1;
    cycle();
    chk("prio_src", 32'(s0[1:0]), 32'd0);
    chk("prio_b",   32'(b0[0]),   32'd1);
    paddle_btn[0] = 1'b0;

    // Stick: both axes over threshold, X wins.
    joy_a[15:0] = 16'h7070;
    repeat (2) cycle();
    chk("stick_src", 32'(s0[1:0]), 32'd1);
    chk("stick_x",   32'(a0[7:0]), 32'h70);
    joy_a[15:0] = 16'h7570;
    repeat (2) cycle();
    chk("stick_x_wins", 32'(a0[7:0]), 32'h70);
    stick_btn[0] = 1'b0;

    // Mouse on channel 1: clamping, saturation, retention.
    mouse_ch = 2'd1;
    repeat (5) mouse_report(50, 0, 2'b00);
    cycle();
    chk("mouse_clamp50", 32'(a0[15:8]), 32'h32);
    chk("mouse_src1",    32'(s0[3:2]),  32'd2);
    chk("mouse_ch0_src", 32'(s0[1:0]),  32'd1);
    chk("mouse_ch0_a",   32'(a0[7:0]),  32'h70);
    repeat (20) mouse_report(10, 0, 2'b00);
    cycle();
    chk("mouse_sat127", 32'(a0[15:8]), 32'h7F);
    mouse_ch = 2'd2;
    repeat (5) mouse_report(-50, 0, 2'b00);
    cycle();
    chk("mouse_ch2_neg", 32'(a0[23:16]), 32'hCE);
    mouse_ch = 2'd1;
    mouse_report(-5, 0, 2'b01);
    cycle();
    chk("mouse_retain", 32'(a0[15:8]), 32'h7A);
    chk("mouse_btn",    32'(b0[1]),    32'd1);
    mouse_report(0, 30, 2'b10);
    cycle();
    chk("mouse_y_axis", 32'(a0[15:8]), 32'h0A);

    // Slew limiter: 80 -> 84 -> 88 -> 8A on ticks only.
    do_reset();
    paddle[7:0] = 8'h0A;
    repeat (3) cycle();
    chk("slew_hold0", 32'(a1[9:0]), aw10(8'h80));
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("slew_t1", 32'(a1[9:0]), aw10(8'h84));
    repeat (2) cycle();
    chk("slew_hold1", 32'(a1[9:0]), aw10(8'h84));
    tick = 1'b1; cycle();
    chk("slew_t2", 32'(a1[9:0]), aw10(8'h88));
    cycle();
    chk("slew_t3", 32'(a1[9:0]), aw10(8'h8A));
    cycle();
    chk("slew_t4", 32'(a1[9:0]), aw10(8'h8A));
    tick = 1'b0;

    // Asynchronous reset mid-slew, then a strobe high at release.
    mouse_ch = 2'd1;
    mouse_report(7, 0, 2'b00);
    paddle[7:0] = 8'h70;
    cycle();
    tick = 1'b1; cycle(); tick = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_a1",   32'(a1[9:0]), 32'h202);
    chk("arst_a0",   32'(a0[7:0]), 32'h80);
    chk("arst_src1", 32'(s0[3:2]), 32'd0);
    check_all();
    @(negedge clk);
    ps2_mouse = '0;
    ps2_mouse[24] = 1'b1;
    ps2_mouse[15:8] = 8'd3;
    paddle = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    cycle();
    chk("arst_mx_clear", 32'(a0[15:8]), 32'h03);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        paddle_btn[ch] = ($urandom_range(0, 9) == 0);
        stick_btn[ch]  = ($urandom_range(0, 9) == 0);
      end
      inv    = 4'($urandom);
      joy_a  = {$urandom, $urandom};
      paddle = $urandom;
      tick   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) mouse_ch = 2'($urandom);
      ps2_mouse[23:0] = 24'($urandom);
      if ($urandom_range(0, 2) == 0) ps2_mouse[24] = ~ps2_mouse[24];
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
